// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: power-up, reset and lock supervisor for the video PLL.
// Sequences PLLPWD/RESET, qualifies LOCK, retries on timeout and gates the pixel clock and reset.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int RELEASE_DLY         = 4,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_pwd_o,
    output logic       pll_reset_o,
    output logic       clk_en_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [2:0] retry_cnt_o
);
    typedef enum logic [2:0] {PWRDN, RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY - 1);
    localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_d;
    logic [1:0]       sync_q;
    logic             lock_s, sys_rst_n_d;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt_o;
        case (state_q)
            PWRDN:     if (cnt_q == RST_LAST) state_d = RESET;
            RESET:     if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = retry_cnt_o < MAX_R ? RESET : FAIL;
                    retry_d = retry_cnt_o < MAX_R ? retry_cnt_o + 3'd1 : retry_cnt_o;
                end
            end
            STABLE:    state_d = !lock_s ? WAIT_LOCK : (cnt_q == STB_LAST ? RUN : STABLE);
            RUN: begin
                if (!lock_s) begin
                    state_d = RESET;
                    retry_d = '0;
                end
            end
            FAIL:      state_d = FAIL;
            default:   state_d = PWRDN;
        endcase
        // a restart request overrides any lock event or timeout decided above
        if (relock_req_i && state_q != PWRDN) begin
            state_d = PWRDN;
            retry_d = '0;
        end
        cnt_d = state_d != state_q ? '0
              : (state_q == FAIL || (state_q == RUN && sys_rst_n_o)) ? cnt_q
              : cnt_q + CNT_W'(1);
        sys_rst_n_d = state_d == RUN && state_q == RUN && (sys_rst_n_o || cnt_q == REL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRDN;
            cnt_q       <= '0;
            sync_q      <= '0;
            pll_pwd_o   <= 1'b1;
            pll_reset_o <= 1'b1;
            clk_en_o    <= 1'b0;
            sys_rst_n_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], pll_lock_i};
            pll_pwd_o   <= state_d == PWRDN || state_d == FAIL;
            pll_reset_o <= state_d == PWRDN || state_d == RESET || state_d == FAIL;
            clk_en_o    <= state_d == RUN;
            sys_rst_n_o <= sys_rst_n_d;
            locked_o    <= state_d == RUN;
            fail_o      <= state_d == FAIL;
            retry_cnt_o <= retry_d;
        end
    end
endmodule
